seg7_page_select: RTL

Upstream feeder for the 8-digit seven-segment driver on the FPGA board. Takes four 32-bit debug sources from the MIPS core (PC, instruction, ALU result, memory read data) and two raw push-buttons. Debounces the buttons, steps through the sources as display pages, and optionally freezes the shown value. Drives the registered 32-bit `data` word that the seven-segment driver latches and displays.

---
 rtl/seg7_page_select.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seg7_page_select.sv
// Purpose   : debounced page/hold selector feeding the 8-digit seven-segment driver.
// Latency   : source -> data 1 cycle in LIVE; button -> pulse 2 sync + DEBOUNCE_CYCLES cycles.
// Backpressure: none; the driver latches data every cycle, outputs are always valid.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   btn_next, btn_hold  raw push-buttons (page advance, freeze toggle)
//   src_pc/instr/alu/mem  page 0..3 debug sources
//   data, page, held    registered display word, page index, frozen flag
// Build option: define SEG7_PAGE_TAG_EN to show the page number in data[31:28].
module seg7_page_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_hold,
  input  logic [31:0] src_pc,
  input  logic [31:0] src_instr,
  input  logic [31:0] src_alu,
  input  logic [31:0] src_mem,
  output logic [31:0] data,
  output logic [1:0]  page,
  output logic        held
);

  localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {LIVE, FROZEN} state_t;

  // Bit 0 = next button, bit 1 = hold button.
  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  acc_q, acc_dly_q;
  logic [23:0] cnt_q [2];

  logic        next_p, hold_p;
  logic [1:0]  page_d;
  logic [31:0] src_sel;
  logic [31:0] data_d;

  state_t      state_q;
  logic [31:0] data_q;
  logic [1:0]  page_q;
  logic        held_q;

  // Synchronizers and debouncers. The counter measures how long the
  // synchronized level has disagreed with the accepted level; any return to
  // agreement restarts it, so only a level held for DEBOUNCE_CYCLES
  // consecutive cycles is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      acc_dly_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= {btn_hold, btn_next};
      sync2_q   <= sync1_q;
      acc_dly_q <= acc_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          acc_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 24'd1;
        end
      end
    end
  end

  // Rising edges of the accepted levels only; releases produce nothing.
  assign next_p = acc_q[0] & ~acc_dly_q[0];
  assign hold_p = acc_q[1] & ~acc_dly_q[1];

  // Page after this cycle's update; wraps 3 -> 0 naturally in 2 bits.
  assign page_d = page_q + {1'b0, next_p};

  always_comb begin
    src_sel = src_pc;
    unique case (page_d)
      2'd0: src_sel = src_pc;
      2'd1: src_sel = src_instr;
      2'd2: src_sel = src_alu;
      2'd3: src_sel = src_mem;
      default: src_sel = src_pc;
    endcase
  end

`ifdef SEG7_PAGE_TAG_EN
  // Leftmost digit shows the page number.
  assign data_d = {2'b00, page_d, 28'h000_0000} | (src_sel & 32'h0FFF_FFFF);
`else
  assign data_d = src_sel;
`endif

  // Hold FSM with registered outputs. Any cycle that changes page or hold
  // state reloads data, so page/held/data always move on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LIVE;
      data_q  <= 32'h0000_0000;
      page_q  <= 2'd0;
      held_q  <= 1'b0;
    end else begin
      page_q <= page_d;
      unique case (state_q)
        LIVE: begin
          data_q <= data_d;
          if (hold_p) begin
            state_q <= FROZEN;
            held_q  <= 1'b1;
          end
        end
        FROZEN: begin
          if (next_p || hold_p) data_q <= data_d;
          if (hold_p) begin
            state_q <= LIVE;
            held_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= LIVE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data = data_q;
  assign page = page_q;
  assign held = held_q;

endmodule
